// File: rtl/sram_uart_pkg.sv
// Shared constants and state encoding for the UART-to-SRAM loader.
// DEF_* values are the board defaults.
package sram_uart_pkg;

    localparam int DEF_ADDR_W    = 19;
    localparam int DEF_DEPTH     = 524288;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_WE_CYC    = 2;
    localparam int DEF_HOLD_CYC  = 1;
    localparam int CNT_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sram_uart_loader_if.sv
// SRAM pin bundle: the loader drives it (master) and the board top consumes it (slave).
// The board top builds the MemDB tristate from MemDB_out and MemDB_oe.
interface sram_uart_loader_if #(parameter int ADDR_W = sram_uart_pkg::DEF_ADDR_W);

    logic [ADDR_W-1:0] MemAdr;
    logic [7:0]        MemDB_out;
    logic              MemDB_oe;
    logic              RamCEn;
    logic              RamOEn;
    logic              RamWEn;

    modport master (output MemAdr, MemDB_out, MemDB_oe, RamCEn, RamOEn, RamWEn);
    modport slave  (input  MemAdr, MemDB_out, MemDB_oe, RamCEn, RamOEn, RamWEn);

endinterface

// File: rtl/sram_write_seq.sv
// Sequences one async-SRAM write: SETUP, then WRITE, then HOLD.
// All pins are registered, so nothing glitches while RamWEn is low.
module sram_write_seq
    import sram_uart_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WE_CYC    = DEF_WE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [7:0]        mem_db_out,
    output logic              mem_db_oe,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic              busy,
    output logic              finish
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WE_LAST    = CNT_W'(WE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] mem_adr_q;
    logic [7:0]        mem_db_out_q;
    logic              mem_db_oe_q;
    logic              ram_cen_q;
    logic              ram_wen_q;
    logic              busy_q;

    assign finish     = (state_q == ST_HOLD) && (cnt_q == HOLD_LAST);
    assign mem_adr    = mem_adr_q;
    assign mem_db_out = mem_db_out_q;
    assign mem_db_oe  = mem_db_oe_q;
    assign ram_cen    = ram_cen_q;
    assign ram_wen    = ram_wen_q;
    assign busy       = busy_q;

    // addr is the caller's next pointer, so the address only moves in IDLE or at HOLD exit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mem_adr_q    <= '0;
            mem_db_out_q <= '0;
            mem_db_oe_q  <= 1'b0;
            ram_cen_q    <= 1'b1;
            ram_wen_q    <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            if (state_q == ST_IDLE || finish) begin
                mem_adr_q <= addr;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_SETUP;
                        cnt_q        <= '0;
                        mem_db_out_q <= data;
                        mem_db_oe_q  <= 1'b1;
                        ram_cen_q    <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q   <= ST_WRITE;
                        cnt_q     <= '0;
                        ram_wen_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == WE_LAST) begin
                        state_q   <= ST_HOLD;
                        cnt_q     <= '0;
                        ram_wen_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (finish) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        mem_db_oe_q <= 1'b0;
                        ram_cen_q   <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sram_uart_loader.sv
// Writes UART bytes sequentially into the external SRAM from address 0.
// Holds the one-byte holding register, the pointer/count, and the done/overrun/restart logic.
module sram_uart_loader
    import sram_uart_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WE_CYC    = DEF_WE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     restart,
    input  logic [7:0]               rx_data,
    input  logic                     rx_data_fresh,
    sram_uart_loader_if.master       mem,
    output logic [ADDR_W:0]          byte_count,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              restart_pend_q, restart_pend_d;

    logic              seq_finish;
    logic              start;
    logic              clear;
    logic              capture;
    logic              drop;
    logic [ADDR_W-1:0] seq_adr;
    logic [7:0]        seq_db;
    logic              seq_oe;
    logic              seq_cen;
    logic              seq_wen;

    // restart always wins over a byte arriving in the same cycle
    assign start   = !busy && !done_q && hold_valid_q && !restart;
    assign clear   = (!busy && restart) || (seq_finish && (restart_pend_q || restart));
    assign capture = rx_data_fresh && !done_q && !restart && (!hold_valid_q || start);
    assign drop    = rx_data_fresh && !done_q && !restart && hold_valid_q && !start;

    always_comb begin
        hold_d         = hold_q;
        hold_valid_d   = hold_valid_q;
        adr_d          = adr_q;
        count_d        = count_q;
        done_d         = done_q;
        overrun_d      = overrun_q;
        restart_pend_d = busy && !seq_finish && (restart_pend_q || restart);

        if (capture) begin
            hold_d       = rx_data;
            hold_valid_d = 1'b1;
        end else if (start) begin
            hold_valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end

        // a restart held back during a write lands on the same edge the write retires
        if (clear) begin
            adr_d        = '0;
            count_d      = '0;
            done_d       = 1'b0;
            overrun_d    = 1'b0;
            hold_valid_d = 1'b0;
        end else if (seq_finish) begin
            adr_d   = adr_q + 1'b1;
            count_d = count_q + 1'b1;
            done_d  = ((count_q + 1'b1) == DEPTH_CNT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q         <= '0;
            hold_valid_q   <= 1'b0;
            adr_q          <= '0;
            count_q        <= '0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
            restart_pend_q <= 1'b0;
        end else begin
            hold_q         <= hold_d;
            hold_valid_q   <= hold_valid_d;
            adr_q          <= adr_d;
            count_q        <= count_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
            restart_pend_q <= restart_pend_d;
        end
    end

    sram_write_seq #(
        .ADDR_W    (ADDR_W),
        .SETUP_CYC (SETUP_CYC),
        .WE_CYC    (WE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .addr       (adr_d),
        .data       (hold_q),
        .mem_adr    (seq_adr),
        .mem_db_out (seq_db),
        .mem_db_oe  (seq_oe),
        .ram_cen    (seq_cen),
        .ram_wen    (seq_wen),
        .busy       (busy),
        .finish     (seq_finish)
    );

    assign mem.MemAdr    = seq_adr;
    assign mem.MemDB_out = seq_db;
    assign mem.MemDB_oe  = seq_oe;
    assign mem.RamCEn    = seq_cen;
    assign mem.RamOEn    = 1'b1;
    assign mem.RamWEn    = seq_wen;
    assign byte_count    = count_q;
    assign done          = done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_sram_uart_loader.sv
// Bench for sram_uart_loader in a small configuration (4 bytes, 2-bit address) so done and wrap are reachable.
// A cycle-level byte-acceptance model predicts every SRAM write; a pin monitor checks each write.
module tb_sram_uart_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int S     = 1;
    localparam int W     = 2;
    localparam int H     = 1;
    localparam int NEVER = 32'h7fffffff;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          restart = 1'b0;
    logic          rx_data_fresh = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [AW:0]   byte_count;
    logic          busy;
    logic          done;
    logic          overrun;

    sram_uart_loader_if #(.ADDR_W(AW)) mem_bus ();

    sram_uart_loader #(
        .ADDR_W    (AW),
        .DEPTH     (DEPTH),
        .SETUP_CYC (S),
        .WE_CYC    (W),
        .HOLD_CYC  (H)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .restart       (restart),
        .rx_data       (rx_data),
        .rx_data_fresh (rx_data_fresh),
        .mem           (mem_bus),
        .byte_count    (byte_count),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // expected SRAM writes as {address, data}, oldest first
    logic [AW+7:0] exp_q[$];

    bit            m_hold_v;
    logic [7:0]    m_hold_b;
    logic [AW-1:0] m_adr;
    int            m_free;
    int            m_done_at;
    int            m_issued;
    bit            m_over;
    bit            m_pend;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_adr     = '0;
        m_issued  = 0;
        m_done_at = NEVER;
        m_over    = 1'b0;
        m_hold_v  = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_free = 0;
        m_pend = 1'b0;
        exp_q.delete();
    endtask

    // one clock cycle of the loader's rules: a write occupies the SRAM for 1+S+W+H cycles
    // from the cycle it is launched out of the holding register
    task automatic model_step(input bit f, input bit r, input logic [7:0] d);
        bit idle_now, done_now, start, accept, drop;
        if (m_pend && cyc >= m_free) begin
            model_clear();
            m_pend = 1'b0;
        end
        idle_now = (cyc >= m_free);
        done_now = (cyc >= m_done_at);
        start    = idle_now && !done_now && m_hold_v && !r;
        accept   = f && !r && !done_now && (!m_hold_v || start);
        drop     = f && !r && !done_now && m_hold_v && !start;
        if (start) begin
            exp_q.push_back({m_adr, m_hold_b});
            m_adr    = m_adr + 1'b1;
            m_issued = m_issued + 1;
            m_free   = cyc + 1 + S + W + H;
            if (m_issued == DEPTH) m_done_at = m_free;
        end
        if (drop) m_over = 1'b1;
        if (r && idle_now) begin
            model_clear();
        end else if (r) begin
            m_pend = 1'b1;
        end else if (accept) begin
            m_hold_b = d;
            m_hold_v = 1'b1;
        end else if (start) begin
            m_hold_v = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input bit f, input bit r, input logic [7:0] d);
        model_step(f, r, d);
        rx_data_fresh = f;
        restart       = r;
        rx_data       = d;
        @(posedge clk);
        #1;
        cyc++;
        rx_data_fresh = 1'b0;
        restart       = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_reset(input string tag);
        check_output(tag,
            32'({mem_bus.MemAdr, mem_bus.MemDB_out, mem_bus.MemDB_oe, mem_bus.RamCEn,
                 mem_bus.RamOEn, mem_bus.RamWEn, byte_count, busy, done, overrun}),
            32'({{AW{1'b0}}, 8'h00, 4'b0111, {(AW+1){1'b0}}, 3'b000}));
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_count"}, 32'(byte_count), 32'(m_issued));
        check_output({tag, "_adr"}, 32'(mem_bus.MemAdr), 32'(m_adr));
        check_output({tag, "_flags"}, 32'({busy, done, overrun, mem_bus.RamCEn, mem_bus.MemDB_oe}),
                     32'({1'b0, (m_issued == DEPTH), m_over, 1'b1, 1'b0}));
    endtask

    logic          mon_prev_we = 1'b1;
    logic          mon_prev_cen;
    logic          mon_prev_oe;
    logic [AW-1:0] mon_prev_adr;
    logic [7:0]    mon_prev_db;
    logic [AW-1:0] mon_fall_adr;
    logic [7:0]    mon_fall_db;
    int            mon_low = 0;

    // pin monitor: setup/hold windows, strobe width and contents of every write
    always @(negedge clk) begin
        if (!rst) begin
            mon_prev_we = 1'b1;
            mon_low     = 0;
        end else begin
            if (mon_prev_we && !mon_bus_we()) begin
                check_output("setup_window",
                    32'({mon_prev_cen, mon_prev_oe, mon_prev_adr, mon_prev_db}),
                    32'({1'b0, 1'b1, mem_bus.MemAdr, mem_bus.MemDB_out}));
                mon_fall_adr = mem_bus.MemAdr;
                mon_fall_db  = mem_bus.MemDB_out;
                mon_low      = 1;
            end else if (!mon_prev_we && !mon_bus_we()) begin
                check_output("we_low_stable",
                    32'({mem_bus.RamCEn, mem_bus.MemDB_oe, mem_bus.MemAdr, mem_bus.MemDB_out}),
                    32'({1'b0, 1'b1, mon_fall_adr, mon_fall_db}));
                mon_low++;
            end else if (!mon_prev_we && mon_bus_we()) begin
                check_output("hold_window",
                    32'({mem_bus.RamCEn, mem_bus.MemDB_oe, mem_bus.RamOEn, mem_bus.MemAdr, mem_bus.MemDB_out}),
                    32'({1'b0, 1'b1, 1'b1, mon_fall_adr, mon_fall_db}));
                check_output("we_width", 32'(mon_low), 32'(W));
                check_output("write_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    check_output("write_content", 32'({mon_fall_adr, mon_fall_db}), 32'(exp_q.pop_front()));
                end
            end
            mon_prev_we  = mon_bus_we();
            mon_prev_cen = mem_bus.RamCEn;
            mon_prev_oe  = mem_bus.MemDB_oe;
            mon_prev_adr = mem_bus.MemAdr;
            mon_prev_db  = mem_bus.MemDB_out;
        end
    end

    function automatic logic mon_bus_we();
        return mem_bus.RamWEn;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_init");
        rst = 1'b1;
        idle_cycles(2);

        $display("[TB] async reset during a write");
        apply_stimulus(1'b1, 1'b0, 8'h3C);
        idle_cycles(2);
        check_output("t1_in_write", 32'(mem_bus.RamWEn), 32'(0));
        #1 rst = 1'b0;
        #1 check_reset("t1_async_reset");
        model_reset();
        #3 rst = 1'b1;
        idle_cycles(8);
        check_quiet("t1_after");

        $display("[TB] single byte timing");
        apply_stimulus(1'b1, 1'b0, 8'hA5);
        check_output("t2_hold_cycle", 32'({busy, mem_bus.RamCEn}), 32'(2'b01));
        idle_cycles(1);
        check_output("t2_setup",
            32'({mem_bus.MemAdr, mem_bus.MemDB_out, mem_bus.MemDB_oe, mem_bus.RamCEn, mem_bus.RamWEn}),
            32'({2'd0, 8'hA5, 3'b101}));
        idle_cycles(1);
        check_output("t2_we_low", 32'(mem_bus.RamWEn), 32'(0));
        idle_cycles(2);
        check_output("t2_hold_phase", 32'({mem_bus.RamWEn, mem_bus.RamCEn, mem_bus.MemAdr}), 32'({2'b10, 2'd0}));
        idle_cycles(1);
        check_output("t2_count_adr", 32'({byte_count, mem_bus.MemAdr}), 32'({3'd1, 2'd1}));
        check_quiet("t2_after");

        $display("[TB] overrun on back-to-back bytes");
        apply_stimulus(1'b0, 1'b1, 8'h00);
        apply_stimulus(1'b1, 1'b0, 8'h11);
        idle_cycles(1);
        apply_stimulus(1'b1, 1'b0, 8'h22);
        idle_cycles(1);
        apply_stimulus(1'b1, 1'b0, 8'h33);
        idle_cycles(12);
        check_output("t3_overrun_count", 32'({overrun, byte_count}), 32'({1'b1, 3'd2}));
        check_quiet("t3_after");

        $display("[TB] fill to depth");
        apply_stimulus(1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1'b1, 1'b0, 8'(i));
            idle_cycles(6);
        end
        check_output("t4_done", 32'({done, byte_count, mem_bus.MemAdr, overrun}), 32'({1'b1, 3'd4, 2'd0, 1'b0}));
        check_quiet("t4_after");

        $display("[TB] restart during a write");
        apply_stimulus(1'b0, 1'b1, 8'h00);
        apply_stimulus(1'b1, 1'b0, 8'h55);
        idle_cycles(7);
        apply_stimulus(1'b1, 1'b0, 8'h66);
        idle_cycles(7);
        apply_stimulus(1'b1, 1'b0, 8'h77);
        idle_cycles(2);
        apply_stimulus(1'b0, 1'b1, 8'h00);
        check_output("t5_write_continues", 32'({mem_bus.RamWEn, mem_bus.MemAdr}), 32'({1'b0, 2'd2}));
        idle_cycles(4);
        check_output("t5_rewound", 32'({byte_count, mem_bus.MemAdr, done, overrun}), 32'(0));
        check_quiet("t5_rewound");
        apply_stimulus(1'b1, 1'b0, 8'h5A);
        idle_cycles(7);
        check_quiet("t5_after");

        $display("[TB] restart and byte together");
        apply_stimulus(1'b0, 1'b1, 8'h00);
        apply_stimulus(1'b1, 1'b1, 8'h99);
        idle_cycles(8);
        check_output("t6_nothing", 32'({byte_count, overrun, busy}), 32'(0));
        check_quiet("t6_after");

        $display("[TB] random traffic");
        for (int burst = 0; burst < 8; burst++) begin
            repeat (50) begin
                apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, 8'($urandom));
            end
            idle_cycles(10);
            check_quiet("rand");
        end

        check_output("writes_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
